// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: drives a valid/ready data bus, aligns store lanes,
// extends load data, and reports misaligned/illegal accesses and bus timeouts.
module rv32i_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        op_done,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;

    logic [1:0]    lat_off;
    logic [2:0]    lat_f3;
    logic [4:0]    lat_rd;
    logic          lat_write;

    logic          accept;
    logic          legal;
    logic          limit_hit;
    logic          rsp_take;
    logic          go_misalign;
    logic          go_timeout;
    logic [3:0]    strb_calc;
    logic [31:0]   wdata_calc;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ext_data;

    assign stall     = req_valid & ~op_done;
    assign accept    = (state == IDLE) & req_valid & (req_read | req_write);
    assign limit_hit = (wait_cnt >= CW'(MAX_WAIT - 1));

    // A request with both read and write set is treated as a store.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr[0];
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = ~req_write;
            3'b101:  legal = ~req_write & ~req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        strb_calc  = '0;
        wdata_calc = '0;
        if (req_write) begin
            case (req_funct3[1:0])
                2'b00: begin
                    strb_calc  = 4'b0001 << req_addr[1:0];
                    wdata_calc = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    strb_calc  = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_calc = {2{req_wdata[15:0]}};
                end
                default: begin
                    strb_calc  = 4'b1111;
                    wdata_calc = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte  = mem_rsp_rdata[{lat_off, 3'b000} +: 8];
        ld_half  = lat_off[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        ext_data = mem_rsp_rdata;
        case (lat_f3)
            3'b000:  ext_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ext_data = {24'h0, ld_byte};
            3'b001:  ext_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ext_data = {16'h0, ld_half};
            default: ext_data = mem_rsp_rdata;
        endcase
    end

    // The awaited handshake always takes priority over the wait limit.
    always_comb begin
        state_next  = state;
        go_misalign = 1'b0;
        go_timeout  = 1'b0;
        rsp_take    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_next = REQ;
                    end else begin
                        state_next  = DONE;
                        go_misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = lat_write ? DONE : RSP;
                end else if (limit_hit) begin
                    state_next = DONE;
                    go_timeout = 1'b1;
                end
            end
            RSP: begin
                if (mem_rsp_valid) begin
                    state_next = DONE;
                    rsp_take   = 1'b1;
                end else if (limit_hit) begin
                    state_next = DONE;
                    go_timeout = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lat_off       <= '0;
            lat_f3        <= '0;
            lat_rd        <= '0;
            lat_write     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wstrb     <= '0;
            mem_wdata     <= '0;
            op_done       <= 1'b0;
            ld_valid      <= 1'b0;
            ld_data       <= '0;
            ld_rd         <= '0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_next;
            mem_req_valid <= (state_next == REQ);
            op_done       <= (state_next == DONE);
            err_misalign  <= go_misalign;
            err_timeout   <= go_timeout;
            ld_valid      <= rsp_take;

            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if ((state == REQ || state == RSP) && wait_cnt != CW'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (accept) begin
                lat_off   <= req_addr[1:0];
                lat_f3    <= req_funct3;
                lat_rd    <= req_rd;
                lat_write <= req_write;
            end

            if (accept && legal) begin
                mem_we    <= req_write;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wstrb <= strb_calc;
                mem_wdata <= wdata_calc;
            end else if (state_next != REQ) begin
                mem_we    <= 1'b0;
                mem_wstrb <= '0;
            end

            if (rsp_take) begin
                ld_data <= ext_data;
                ld_rd   <= lat_rd;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: vector table of single accesses plus
// hand-written sequences for back-pressure, timeout and mid-operation reset.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        op_done;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        err_misalign;
    logic        err_timeout;

    int n_pass = 0;
    int n_total = 0;

    rv32i_lsu #(.MAX_WAIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .op_done       (op_done),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_rd         (ld_rd),
        .err_misalign  (err_misalign),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_reset(input string p);
        chk({p, " ctrl"}, {22'h0, mem_req_valid, mem_we, mem_wstrb, op_done, ld_valid,
                           err_misalign, err_timeout}, 32'h0);
        chk({p, " mem_addr"}, mem_addr, 32'h0);
        chk({p, " mem_wdata"}, mem_wdata, 32'h0);
        chk({p, " ld_data"}, ld_data, 32'h0);
        chk({p, " ld_rd"}, {27'h0, ld_rd}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit fin;
        bit seen_req;
        bit pend;
        bit stall_ok;
        int exp_lat;
        exp_lat = v.e_mis ? 1 : (v.wr_op ? 2 : 3);
        @(negedge clk);
        req_valid = 1'b1;  req_read = v.rd_op;  req_write = v.wr_op;
        req_funct3 = v.f3; req_addr = v.addr;   req_wdata = v.wdata;  req_rd = v.rd;
        mem_req_ready = 1'b1;  mem_rsp_rdata = v.rdata;  mem_rsp_valid = 1'b0;
        cyc = 0; fin = 0; seen_req = 0; pend = 0; stall_ok = 1;
        while (!fin && cyc < 16) begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = pend;
            pend = mem_req_valid && mem_req_ready && !mem_we;
            if (mem_req_valid && !seen_req) begin
                seen_req = 1;
                chk({v.name, " mem_addr"}, mem_addr, v.e_addr);
                chk({v.name, " mem_we"}, {31'h0, mem_we}, {31'h0, v.wr_op});
                chk({v.name, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, v.e_strb});
                if (v.wr_op) chk({v.name, " mem_wdata"}, mem_wdata, v.e_wdata);
            end
            if (op_done) begin
                fin = 1;
                chk({v.name, " latency"}, cyc, exp_lat);
                chk({v.name, " err_misalign"}, {31'h0, err_misalign}, {31'h0, v.e_mis});
                chk({v.name, " err_timeout"}, {31'h0, err_timeout}, 32'h0);
                chk({v.name, " ld_valid"}, {31'h0, ld_valid}, {31'h0, v.rd_op & ~v.e_mis});
                if (v.rd_op && !v.e_mis) begin
                    chk({v.name, " ld_data"}, ld_data, v.e_ld);
                    chk({v.name, " ld_rd"}, {27'h0, ld_rd}, {27'h0, v.rd});
                end
                chk({v.name, " stall at done"}, {31'h0, stall}, 32'h0);
                req_valid = 1'b0;
                mem_rsp_valid = 1'b0;
            end else if (!stall) begin
                stall_ok = 0;
            end
        end
        chk({v.name, " op_done seen"}, {31'h0, fin}, 32'h1);
        chk({v.name, " stall held"}, {31'h0, stall_ok}, 32'h1);
        chk({v.name, " bus request issued"}, {31'h0, seen_req}, {31'h0, ~v.e_mis});
        req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_limit(input string name, input int rsp_cyc,
                              input logic [31:0] rdata, input logic exp_to);
        int cyc;
        bit fin;
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h5000; req_rd = 5'd12;
        mem_req_ready = 1'b1; mem_rsp_rdata = rdata; mem_rsp_valid = 1'b0;
        cyc = 0; fin = 0;
        while (!fin && cyc < 16) begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = (cyc == rsp_cyc);
            if (op_done) begin
                fin = 1;
                chk({name, " latency"}, cyc, 5);
                chk({name, " err_timeout"}, {31'h0, err_timeout}, {31'h0, exp_to});
                chk({name, " ld_valid"}, {31'h0, ld_valid}, {31'h0, ~exp_to});
                chk({name, " err_misalign"}, {31'h0, err_misalign}, 32'h0);
                if (!exp_to) begin
                    chk({name, " ld_data"}, ld_data, 32'hA5A5A5A5);
                    chk({name, " ld_rd"}, {27'h0, ld_rd}, 32'd12);
                end
                req_valid = 1'b0;
                mem_rsp_valid = 1'b0;
            end
        end
        chk({name, " op_done seen"}, {31'h0, fin}, 32'h1);
        req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   cyc;
        bit   fin;
        bit   stable_ok;
        bit   stall_ok;
        bit   quiet_ok;

        //                 name          rd  wr  f3      addr          wdata         rd     rdata         e_addr        e_strb   e_wdata       e_ld          mis
        vecs.push_back('{"SB 1003",   1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABBCCDD, 5'd0,  32'h0,         32'h0000_1000, 4'b1000, 32'hDDDDDDDD, 32'h0,        1'b0});
        vecs.push_back('{"SH 1002",   1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h12345678, 5'd0,  32'h0,         32'h0000_1000, 4'b1100, 32'h56785678, 32'h0,        1'b0});
        vecs.push_back('{"SB 1000",   1'b0, 1'b1, 3'b000, 32'h0000_1000, 32'h000000A7, 5'd0,  32'h0,         32'h0000_1000, 4'b0001, 32'hA7A7A7A7, 32'h0,        1'b0});
        vecs.push_back('{"SW 1004",   1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hCAFEBABE, 5'd0,  32'h0,         32'h0000_1004, 4'b1111, 32'hCAFEBABE, 32'h0,        1'b0});
        vecs.push_back('{"LB 2001",   1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0,        5'd5,  32'h000080FF,  32'h0000_2000, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{"LBU 2001",  1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0,        5'd6,  32'h000080FF,  32'h0000_2000, 4'b0000, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{"LH 2002",   1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        5'd7,  32'h80011234,  32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{"LHU 2002",  1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        5'd8,  32'h80011234,  32'h0000_2000, 4'b0000, 32'h0,        32'h00008001, 1'b0});
        vecs.push_back('{"LW 2004",   1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0,        5'd31, 32'hDEADBEEF,  32'h0000_2004, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"LB 2000",   1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'h0,        5'd1,  32'h0000007F,  32'h0000_2000, 4'b0000, 32'h0,        32'h0000007F, 1'b0});
        vecs.push_back('{"LBU 2003",  1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0,        5'd2,  32'h9A000000,  32'h0000_2000, 4'b0000, 32'h0,        32'h0000009A, 1'b0});
        vecs.push_back('{"LW 3002",   1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0,        5'd3,  32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"SH 1001",   1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h1111,     5'd0,  32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"LD f3=011", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        5'd4,  32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"S f3=100",  1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        5'd0,  32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"LHU 2001",  1'b1, 1'b0, 3'b101, 32'h0000_2001, 32'h0,        5'd9,  32'h0,         32'h0,         4'b0000, 32'h0,        32'h0,        1'b1});

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        chk("por stall", {31'h0, stall}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Back-pressure: ready low for three REQ cycles, handshake on the fourth.
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h4008; req_wdata = 32'h11223344; req_rd = 5'd0;
        mem_req_ready = 1'b0;
        cyc = 0; fin = 0; stable_ok = 1; stall_ok = 1;
        while (!fin && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (op_done) begin
                fin = 1;
                chk("backpressure latency", cyc, 5);
                chk("backpressure err_timeout", {31'h0, err_timeout}, 32'h0);
                chk("backpressure stall at done", {31'h0, stall}, 32'h0);
                req_valid = 1'b0;
            end else begin
                if (!stall) stall_ok = 0;
                if (cyc <= 4 && !(mem_req_valid && mem_we && mem_addr == 32'h4008 &&
                                  mem_wstrb == 4'hF && mem_wdata == 32'h11223344))
                    stable_ok = 0;
                if (cyc == 4) mem_req_ready = 1'b1;
            end
        end
        chk("backpressure op_done seen", {31'h0, fin}, 32'h1);
        chk("backpressure fields stable", {31'h0, stable_ok}, 32'h1);
        chk("backpressure stall held", {31'h0, stall_ok}, 32'h1);
        req_valid = 1'b0;
        @(negedge clk);

        load_limit("rsp at limit", 4, 32'hA5A5A5A5, 1'b0);
        load_limit("timeout", 0, 32'h0, 1'b1);

        // Late response after the timeout must not produce a result.
        mem_rsp_rdata = 32'h12345678;
        quiet_ok = 1;
        for (int k = 0; k < 2; k++) begin
            mem_rsp_valid = 1'b1;
            @(negedge clk);
            if (ld_valid || op_done || mem_req_valid) quiet_ok = 0;
        end
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        if (ld_valid || op_done) quiet_ok = 0;
        chk("spurious rsp ignored", {31'h0, quiet_ok}, 32'h1);

        // Reset while waiting in RSP.
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h6000; req_rd = 5'd9;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid REQ valid", {31'h0, mem_req_valid}, 32'h1);
        @(negedge clk);
        chk("rst-mid in RSP", {31'h0, mem_req_valid | op_done}, 32'h0);
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_reset("rst-mid");
        rst_n = 1'b1;
        mem_rsp_rdata = 32'hFFFFFFFF;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid late rsp dropped", {30'h0, ld_valid, op_done}, 32'h0);

        run_vec('{"LW after reset", 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd9,
                  32'h0BADF00D, 32'h0000_6000, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
